// File: rtl/fp8_pkg.sv
// fp8_pkg: shared FP8 E4M3 constants, accumulator state encoding and field helpers.
//   FP8 layout {sign, exp[3:0], frac[2:0]}, exponent bias 7, exp==0 is subnormal.
package fp8_pkg;
    localparam int FP8_W  = 8;
    localparam int EXP_W  = 4;
    localparam int FRAC_W = 3;

    localparam logic [FP8_W-1:0] FP8_ZERO    = 8'h00;
    localparam logic [EXP_W-1:0] FP8_EXP_MAX = 4'hF;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    function automatic logic [EXP_W-1:0] exp_of(input logic [FP8_W-1:0] v);
        return v[FRAC_W +: EXP_W];
    endfunction
endpackage

// File: rtl/fp8_e4m3_adder.sv
// fp8_e4m3_adder: combinational FP8 E4M3 adder.
//   a, b : FP8 operands
//   sum  : a+b rounded to nearest-even; overflow saturates to +/-448 (0x7E/0xFE),
//          NaN operands give 0x7F, an exact-zero sum is +0.
module fp8_e4m3_adder
    import fp8_pkg::*;
(
    input  logic [FP8_W-1:0] a,
    input  logic [FP8_W-1:0] b,
    output logic [FP8_W-1:0] sum
);
    // Every E4M3 value is an integer multiple of 2^-9; the largest fits in 18 bits,
    // so a sum of two is exact in 19 bits of magnitude.
    localparam int MAG_W = 19;

    function automatic logic [MAG_W-1:0] align(input logic [FP8_W-1:0] v);
        logic [3:0] m;
        logic [3:0] e;
        m = {exp_of(v) != 4'd0, v[2:0]};
        e = (exp_of(v) == 4'd0) ? 4'd1 : exp_of(v);
        return MAG_W'(m) << (e - 4'd1);
    endfunction

    logic signed [MAG_W:0] sa, sb, tot;
    logic [MAG_W-1:0] mag;
    logic             neg;
    logic [4:0]       p, shift, sh1, e;
    logic [4:0]       mant;
    logic             guard, sticky;

    always_comb begin
        sa     = a[7] ? -$signed({1'b0, align(a)}) : $signed({1'b0, align(a)});
        sb     = b[7] ? -$signed({1'b0, align(b)}) : $signed({1'b0, align(b)});
        tot    = sa + sb;
        neg    = tot[MAG_W];
        mag    = neg ? MAG_W'(-tot) : tot[MAG_W-1:0];
        p      = 5'd0;
        for (int i = 0; i < MAG_W; i++)
            if (mag[i]) p = 5'(i);
        shift  = 5'd0;
        sh1    = 5'd0;
        e      = 5'd0;
        mant   = 5'd0;
        guard  = 1'b0;
        sticky = 1'b0;
        sum    = FP8_ZERO;

        if (a[6:0] == 7'h7F || b[6:0] == 7'h7F) begin
            sum = 8'h7F;
        end else if (mag == '0) begin
            sum = FP8_ZERO;
        end else if (p <= 5'd3) begin
            // Subnormal / smallest-normal range is exact at this resolution.
            sum = {neg, 3'b000, mag[3], mag[2:0]};
        end else begin
            shift  = p - 5'd3;
            sh1    = shift - 5'd1;
            e      = shift + 5'd1;
            mant   = {1'b0, 4'(mag >> shift)};
            guard  = mag[sh1];
            sticky = |(mag & ((MAG_W'(1) << sh1) - MAG_W'(1)));
            if (guard && (sticky || mant[0]))
                mant = mant + 5'd1;
            if (mant[4]) begin
                mant = 5'd8;
                e    = e + 5'd1;
            end
            // exp 15 / frac 7 is the NaN code, so 448 is the top finite value.
            if (e > 5'd15 || (e == 5'd15 && mant[2:0] == 3'd7))
                sum = {neg, 7'h7E};
            else
                sum = {neg, e[3:0], mant[2:0]};
        end
    end
endmodule

// File: rtl/fp8_e4m3_accumulator.sv
// fp8_e4m3_accumulator: folds a valid/ready FP8 E4M3 stream into one sum per packet.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : element handshake; in_data element, in_last closes packet
//   out_valid/out_ready : result handshake; out_data sum, out_count elements folded
//   out_sat             : present only when FP8_ACC_SAT_EN is defined; sticky flag
//                         set when any partial sum has exponent 4'hF
// Packets are force-closed after MAX_LEN elements.
module fp8_e4m3_accumulator
    import fp8_pkg::*;
#(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP8_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP8_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
`ifdef FP8_ACC_SAT_EN
    ,
    output logic             out_sat
`endif
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_t           state;
    logic [FP8_W-1:0] acc, add_sum;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             accept;

    fp8_e4m3_adder u_add (.a(acc), .b(in_data), .sum(add_sum));

    assign in_ready = (state != HOLD);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + CNT_W'(1);

`ifdef FP8_ACC_SAT_EN
    logic sat, first_sat, next_sat;
    assign first_sat = (exp_of(in_data) == FP8_EXP_MAX);
    assign next_sat  = sat || (exp_of(add_sum) == FP8_EXP_MAX);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= FP8_ZERO;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= FP8_ZERO;
            out_count <= '0;
`ifdef FP8_ACC_SAT_EN
            sat       <= 1'b0;
            out_sat   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    // First element bypasses the adder.
                    acc <= in_data;
                    cnt <= CNT_W'(1);
`ifdef FP8_ACC_SAT_EN
                    sat <= first_sat;
`endif
                    if (in_last || MAX_LEN == 1) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                        out_count <= CNT_W'(1);
`ifdef FP8_ACC_SAT_EN
                        out_sat   <= first_sat;
`endif
                    end else begin
                        state <= ACC;
                    end
                end
                ACC: if (accept) begin
                    acc <= add_sum;
                    cnt <= cnt_inc;
`ifdef FP8_ACC_SAT_EN
                    sat <= next_sat;
`endif
                    if (in_last || cnt_inc == MAX_CNT) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= add_sum;
                        out_count <= cnt_inc;
`ifdef FP8_ACC_SAT_EN
                        out_sat   <= next_sat;
`endif
                    end
                end
                HOLD: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    cnt       <= '0;
`ifdef FP8_ACC_SAT_EN
                    sat       <= 1'b0;
                    out_sat   <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp8_e4m3_accumulator.sv
// Testbench for fp8_e4m3_accumulator (MAX_LEN=4). Reference model works on real
// values: decode, add exactly, pick the nearest E4M3 code (ties to even, clamp to 448).
module tb_fp8_e4m3_accumulator;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_last;
    logic [7:0]       in_data;
    logic             out_valid, out_ready;
    logic [7:0]       out_data;
    logic [CNT_W-1:0] out_count;
`ifdef FP8_ACC_SAT_EN
    logic             out_sat;
`endif

    fp8_e4m3_accumulator #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
`ifdef FP8_ACC_SAT_EN
        , .out_sat(out_sat)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; int count; bit sat; } res_t;
    res_t exp_q[$];

    int checks = 0;
    int errors = 0;
    bit rand_ready = 0;

    bit         m_open = 0;
    logic [7:0] m_acc;
    int         m_cnt;
    bit         m_sat;

    function automatic real dec(input logic [7:0] c);
        int  e, f;
        real v;
        e = int'(c[6:3]);
        f = int'(c[2:0]);
        if (e == 0) v = (f / 8.0) * (2.0 ** (-6));
        else        v = (1.0 + f / 8.0) * (2.0 ** (e - 7));
        return c[7] ? -v : v;
    endfunction

    function automatic logic [7:0] enc(input real s);
        real        a, d, best_d;
        logic [7:0] best;
        if (s == 0.0) return 8'h00;
        a = (s < 0.0) ? -s : s;
        best = 8'h7E;
        if (a < 448.0) begin
            best_d = 1.0e9;
            for (int c = 0; c <= 126; c++) begin
                d = dec(8'(c)) - a;
                if (d < 0.0) d = -d;
                if (d < best_d || (d == best_d && (c % 2) == 0)) begin
                    best_d = d;
                    best   = 8'(c);
                end
            end
        end
        return (s < 0.0) ? {1'b1, best[6:0]} : best;
    endfunction

    function automatic void model_push(input logic [7:0] d, input bit last);
        res_t r;
        if (!m_open) begin
            m_acc  = d;
            m_cnt  = 1;
            m_sat  = 0;
            m_open = 1;
        end else begin
            m_acc = enc(dec(m_acc) + dec(d));
            m_cnt++;
        end
        if (m_acc[6:3] == 4'hF) m_sat = 1;
        if (last || m_cnt == MAX_LEN) begin
            r.data = m_acc; r.count = m_cnt; r.sat = m_sat;
            exp_q.push_back(r);
            m_open = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: pick out_ready, score any result handshaking at the coming edge.
    task automatic cycle();
        res_t r;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                r = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(r.data));
                chk("out_count", 32'(out_count), 32'(r.count));
`ifdef FP8_ACC_SAT_EN
                chk("out_sat", 32'(out_sat), 32'(r.sat));
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input bit last);
        bit took;
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        do begin
            took = in_ready;
            cycle();
            n++;
        end while (!took && n < 50);
        chk("in_accept", 32'(took), 32'd1);
        if (took) model_push(d, last);
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    endtask

    initial begin
        int n;
        int len;
        logic [7:0] d;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // 1.0 x4 -> 4.0, result one cycle after last accept
        push(8'h38, 0); push(8'h38, 0); push(8'h38, 0); push(8'h38, 1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h48);
        chk("t1_count", 32'(out_count), 32'd4);
        cycle();

        // 1.0 + -1.0 -> +0
        push(8'h38, 0); push(8'hB8, 1);
        chk("t2_data", 32'(out_data), 32'h00);
        chk("t2_count", 32'(out_count), 32'd2);
        cycle();

        // single -2.0
        push(8'hC0, 1);
        chk("t3_data", 32'(out_data), 32'hC0);
        chk("t3_count", 32'(out_count), 32'd1);
        cycle();

        // backpressure
        out_ready = 1'b0;
        push(8'h38, 0); push(8'h38, 1);
        in_valid = 1'b1; in_data = 8'h38; in_last = 1'b1;
        repeat (5) begin
            chk("t4_valid", 32'(out_valid), 32'd1);
            chk("t4_data", 32'(out_data), 32'h40);
            chk("t4_count", 32'(out_count), 32'd2);
            chk("t4_in_ready", 32'(in_ready), 32'd0);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        chk("t4_released", 32'(out_valid), 32'd0);
        chk("t4_ready_back", 32'(in_ready), 32'd1);
        in_valid = 1'b0; in_last = 1'b0;

        // forced close at MAX_LEN
        for (int i = 0; i < 4; i++) push(8'h38, 0);
        chk("t5a_data", 32'(out_data), 32'h48);
        chk("t5a_count", 32'(out_count), 32'd4);
        push(8'h38, 0); push(8'h38, 1);
        chk("t5b_data", 32'(out_data), 32'h40);
        chk("t5b_count", 32'(out_count), 32'd2);
        cycle();

        // reset mid-packet discards partial sum
        push(8'h38, 0); push(8'h38, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_open = 0;
        chk("t6_no_valid", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        push(8'h38, 0); push(8'h38, 1);
        chk("t6_data", 32'(out_data), 32'h40);
        chk("t6_count", 32'(out_count), 32'd2);
        cycle();

`ifdef FP8_ACC_SAT_EN
        push(8'h78, 0); push(8'h78, 1);
        chk("t7_sat", 32'(out_sat), 32'd1);
        chk("t7_data", 32'(out_data), 32'h7E);
        cycle();
        push(8'h38, 1);
        chk("t7_sat_clr", 32'(out_sat), 32'd0);
        cycle();
`endif

        // randomized packets with bubbles and random downstream stalls
        rand_ready = 1;
        for (int p = 0; p < 40; p++) begin
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                do begin
                    d = 8'($urandom);
                    if ($urandom_range(0, 1) == 0) d[6:3] = 4'($urandom_range(4, 9));
                end while (d[6:0] == 7'h7F);
                push(d, i == len - 1);
                if ($urandom_range(0, 3) == 0) cycle();
            end
        end
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        rand_ready = 0;
        out_ready = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
